pixel_write_buffer: RTL and testbench

- Sits directly downstream of the screen-drawing engines (fillscreen, circle and similar).
- Consumes their per-cycle plot strobes (x, y, colour, plot), clips off-screen coordinates and buffers pixels in a small FIFO.
- Converts each accepted pixel to a linear framebuffer address and issues memory writes under a valid/ready handshake.
- Decouples engines that plot every cycle from a framebuffer port that can stall, e.g. when arbitrated against scan-out.

---
 rtl/pixel_write_buffer.sv | 93 +++++++++
 tb/tb_pixel_write_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: clips plot strobes, buffers pixels in a FIFO and issues framebuffer writes
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_x, in_y, in_colour       pixel from the drawing engines, valid when in_plot
//   in_ready                    FIFO not full (advisory)
//   mem_addr, mem_colour        framebuffer write (addr = y*SCREEN_W + x)
//   mem_we, mem_ready           write valid/ready handshake
//   idle                        nothing buffered or pending
//   overflow, clr_overflow      sticky on-screen drop flag and its clear
//   drop_count                  saturating count of discarded pixels (PIXEL_WRITE_BUFFER_DROP_COUNT_EN only)
module pixel_write_buffer #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_plot,
    output logic        in_ready,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_colour,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        idle,
    output logic        overflow,
    input  logic        clr_overflow
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
    ,output logic [15:0] drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [7:0]  W8  = 8'(SCREEN_W);
    localparam logic [6:0]  H7  = 7'(SCREEN_H);
    localparam logic [14:0] W15 = 15'(SCREEN_W);
    logic [17:0]   buf_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          on_screen, full, push, pop, load, drop_full;
    logic [7:0]    head_x;
    logic [6:0]    head_y;
    logic [2:0]    head_c;
    always_comb begin
        on_screen = (in_x < W8) && (in_y < H7);
        full      = count == FULL;
        push      = in_plot && on_screen && !full;
        drop_full = in_plot && on_screen && full;
        // the output register reloads whenever it is empty or its write is being accepted
        load      = !mem_we || mem_ready;
        pop       = load && count != '0;
        {head_x, head_y, head_c} = buf_q[rd_ptr];
    end
    assign in_ready = !full;
    assign idle     = count == '0 && !mem_we;
    always_ff @(posedge clk)
        if (push) buf_q[wr_ptr] <= {in_x, in_y, in_colour};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_colour <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (load) mem_we <= pop;
            if (pop) begin
                mem_addr   <= {8'd0, head_y} * W15 + {7'd0, head_x};
                mem_colour <= head_c;
            end
            overflow <= drop_full | (overflow & ~clr_overflow);
        end
    end
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
    logic drop;
    assign drop = in_plot && (!on_screen || full);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= '0;
        else
            drop_count <= clr_overflow ? {15'd0, drop} :
                          (drop && drop_count != '1) ? drop_count + 16'd1 : drop_count;
    end
`endif
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb_pixel_write_buffer: scoreboard bench for pixel_write_buffer against a queue-level model
module tb_pixel_write_buffer;
    localparam int DEPTH = 16, SW = 160, SH = 120;
    typedef struct { logic [14:0] a; logic [2:0] c; } pix_t;
    logic        clk = 0, rst_n = 0;
    logic [7:0]  in_x = 0;
    logic [6:0]  in_y = 0;
    logic [2:0]  in_colour = 0;
    logic        in_plot = 0, mem_ready = 1, clr_overflow = 0;
    logic        in_ready, mem_we, idle, overflow;
    logic [14:0] mem_addr;
    logic [2:0]  mem_colour;
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif
    pixel_write_buffer #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_plot(in_plot), .in_ready(in_ready), .mem_addr(mem_addr), .mem_colour(mem_colour),
        .mem_we(mem_we), .mem_ready(mem_ready), .idle(idle), .overflow(overflow),
        .clr_overflow(clr_overflow)
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // model: occupancy of the FIFO, whether the output stage holds a pixel, and the expected write order
    pix_t sb[$];
    int   m_cnt, m_dc;
    bit   m_out, m_ov;
    always @(posedge clk or negedge rst_n) begin
        bit full, on, drop;
        if (!rst_n) begin
            m_cnt = 0; m_out = 0; m_ov = 0; m_dc = 0;
            sb.delete();
        end else begin
            full = (m_cnt == DEPTH);
            on   = (in_x < SW) && (in_y < SH);
            drop = in_plot && (!on || full);
            if (!m_out || mem_ready) begin
                if (m_cnt > 0) begin m_cnt--; m_out = 1; end
                else m_out = 0;
            end
            if (in_plot && on && !full) begin
                m_cnt++;
                sb.push_back('{15'(int'(in_y) * SW + int'(in_x)), in_colour});
            end
            if (clr_overflow) m_ov = 0;
            if (in_plot && on && full) m_ov = 1;
            m_dc = clr_overflow ? int'(drop) : (drop && m_dc < 65535) ? m_dc + 1 : m_dc;
        end
    end
    // monitor: compares each accepted write with the scoreboard head plus the status outputs
    bit          prev_hold;
    logic [14:0] prev_a;
    logic [2:0]  prev_c;
    always @(negedge clk) begin
        pix_t p;
        if (!rst_n) prev_hold = 0;
        else begin
            chk("mem_we", mem_we, m_out);
            chk("in_ready", in_ready, m_cnt != DEPTH);
            chk("idle", idle, m_cnt == 0 && !m_out);
            chk("overflow", overflow, m_ov);
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
            chk("drop_count", drop_count, m_dc);
`endif
            if (prev_hold && mem_we) begin
                chk("hold_addr", mem_addr, prev_a);
                chk("hold_colour", mem_colour, prev_c);
            end
            if (mem_we && mem_ready) begin
                if (sb.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    p = sb.pop_front();
                    chk("wr_addr", mem_addr, p.a);
                    chk("wr_colour", mem_colour, p.c);
                end
            end
            prev_hold = mem_we && !mem_ready;
            prev_a = mem_addr;
            prev_c = mem_colour;
        end
    end
    task automatic step(input logic p, input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] c, input logic mr, input logic cl);
        in_plot = p; in_x = x; in_y = y; in_colour = c; mem_ready = mr; clr_overflow = cl;
        @(posedge clk);
        #2;
    endtask
    task automatic wait_n(input int n, input logic mr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, mr, 0);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_colour", mem_colour, 0);
        chk("rst_idle", idle, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        // single pixel: address 2*160+3
        step(1, 3, 2, 5, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 323);
        chk("t1_colour", mem_colour, 5);
        step(0, 0, 0, 0, 1, 0);
        chk("t1_we_drop", mem_we, 0);
        chk("t1_idle", idle, 1);
        // full-screen stream
        for (int x = 0; x < SW; x++)
            for (int y = 0; y < SH; y++)
                step(1, 8'(x), 7'(y), 3'(x % 8), 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("t2_last_addr", mem_addr, 19199);
        chk("t2_last_colour", mem_colour, 7);
        wait_n(4, 1);
        chk("t2_overflow", overflow, 0);
        // stalled memory: 17 held, 3 dropped
        for (int i = 0; i < 20; i++) step(1, 8'(i), 7'(i), 3'(i), 0, 0);
        wait_n(3, 0);
        chk("t3_overflow", overflow, 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_held_addr", mem_addr, 0);
        wait_n(25, 1);
        chk("t3_idle", idle, 1);
        // clipping
        step(0, 0, 0, 0, 1, 1);
        step(1, 160, 0, 1, 1, 0);
        step(1, 0, 120, 2, 1, 0);
        step(1, 159, 119, 3, 1, 0);
        wait_n(4, 1);
        chk("t4_overflow", overflow, 0);
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
        chk("t4_drop_count", drop_count, 2);
`endif
        // overflow set wins over clear, then clear alone
        for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 1, 0, 0);
        step(1, 50, 50, 2, 0, 1);
        chk("t5_set_wins", overflow, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t5_cleared", overflow, 0);
        wait_n(25, 1);
        // asynchronous reset with buffered pixels
        for (int i = 0; i < 9; i++) step(1, 8'(i + 10), 7'(i), 3'(i), 0, 0);
        chk("t6_we_before", mem_we, 1);
        rst_n = 0;
        #1 chk("t6_async_we", mem_we, 0);
        @(posedge clk); @(posedge clk); #2 rst_n = 1;
        wait_n(5, 1);
        chk("t6_idle", idle, 1);
        // randomized traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(99) < 70, 8'($urandom_range(170)), 7'($urandom_range(127)),
                 3'($urandom), $urandom_range(99) < 60, $urandom_range(99) < 5);
        wait_n(30, 1);
        chk("drain_empty", sb.size(), 0);
        chk("drain_idle", idle, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
